// File: rtl/cloud_sprite_renderer.sv
// Circular cloud sprite renderer: generates the frame tick, shadows the cloud
// geometry per frame, tests each pixel for inside/rim membership and counts coverage.
module cloud_sprite_renderer #(
   parameter int unsigned RIM_W = 2
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [9:0]  CloudX,
   input  logic [9:0]  CloudY,
   input  logic [9:0]  CloudS,
   input  logic [9:0]  DrawX,
   input  logic [9:0]  DrawY,
   input  logic        vs,
   input  logic        blank,
   output logic        frame_tick,
   output logic        cloud_on,
   output logic        cloud_rim,
   output logic [18:0] pix_count,
   output logic [7:0]  frame_cnt
);

   localparam logic [9:0] RIM = 10'(RIM_W);

   logic        vs_d;
   logic [9:0]  s_x;
   logic [9:0]  s_y;
   logic [9:0]  s_s;

   logic signed [10:0] dx;
   logic signed [10:0] dy;
   logic [9:0]  adx_c;
   logic [9:0]  ady_c;
   logic [9:0]  r_in_c;

   logic [9:0]  adx;
   logic [9:0]  ady;
   logic [9:0]  r_in;
   logic [9:0]  s1_s;
   logic        vis1;

   logic [19:0] adx2;
   logic [19:0] ady2;
   logic [20:0] d2;
   logic [19:0] s2;
   logic [19:0] rin2;
   logic        on_c;
   logic        rim_c;

   logic [18:0] acc;
   logic        acc_full;

   // vs_d resets to 0 so a vs already low at release cannot look like an edge
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         vs_d       <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         vs_d       <= vs;
         frame_tick <= vs_d & ~vs;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         s_x <= '0;
         s_y <= '0;
         s_s <= '0;
      end else if (frame_tick) begin
         s_x <= CloudX;
         s_y <= CloudY;
         s_s <= CloudS;
      end
   end

   always_comb begin
      dx     = signed'({1'b0, DrawX}) - signed'({1'b0, s_x});
      dy     = signed'({1'b0, DrawY}) - signed'({1'b0, s_y});
      adx_c  = dx[10] ? (~dx[9:0] + 10'd1) : dx[9:0];
      ady_c  = dy[10] ? (~dy[9:0] + 10'd1) : dy[9:0];
      r_in_c = (s_s > RIM) ? (s_s - RIM) : '0;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         adx  <= '0;
         ady  <= '0;
         r_in <= '0;
         s1_s <= '0;
         vis1 <= 1'b0;
      end else begin
         adx  <= adx_c;
         ady  <= ady_c;
         r_in <= r_in_c;
         s1_s <= s_s;
         vis1 <= blank;
      end
   end

   // Radius travels with the pixel so both squares in stage 2 belong to one frame
   always_comb begin
      adx2  = {10'd0, adx} * {10'd0, adx};
      ady2  = {10'd0, ady} * {10'd0, ady};
      d2    = {1'b0, adx2} + {1'b0, ady2};
      s2    = {10'd0, s1_s} * {10'd0, s1_s};
      rin2  = {10'd0, r_in} * {10'd0, r_in};
      on_c  = vis1 & (d2 <= {1'b0, s2});
      rim_c = on_c & (d2 > {1'b0, rin2});
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         cloud_on  <= 1'b0;
         cloud_rim <= 1'b0;
      end else begin
         cloud_on  <= on_c;
         cloud_rim <= rim_c;
      end
   end

   assign acc_full = (acc == '1);

   // The pixel visible on the tick edge belongs to the frame being reported
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         acc       <= '0;
         pix_count <= '0;
         frame_cnt <= '0;
      end else if (frame_tick) begin
         pix_count <= (cloud_on && !acc_full) ? acc + 19'd1 : acc;
         acc       <= '0;
         frame_cnt <= frame_cnt + 8'd1;
      end else if (cloud_on && !acc_full) begin
         acc <= acc + 19'd1;
      end
   end

endmodule

// File: tb/tb_cloud_sprite_renderer.sv
// Directed bench for cloud_sprite_renderer: tick generation, shadow latch,
// circle/rim membership, blanking, coverage count and reset behaviour.
module tb_cloud_sprite_renderer;

   logic        Clk;
   logic        Reset_n;
   logic [9:0]  CloudX;
   logic [9:0]  CloudY;
   logic [9:0]  CloudS;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic        vs;
   logic        blank;
   logic        frame_tick;
   logic        cloud_on;
   logic        cloud_rim;
   logic [18:0] pix_count;
   logic [7:0]  frame_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_frames = 0;

   cloud_sprite_renderer #(.RIM_W(2)) dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .CloudX     (CloudX),
      .CloudY     (CloudY),
      .CloudS     (CloudS),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .vs         (vs),
      .blank      (blank),
      .frame_tick (frame_tick),
      .cloud_on   (cloud_on),
      .cloud_rim  (cloud_rim),
      .pix_count  (pix_count),
      .frame_cnt  (frame_cnt)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Drive one pixel and return the outputs two cycles later
   task automatic probe(input int x, input int y, input logic b,
                        output logic on, output logic rim);
      @(negedge Clk);
      DrawX = 10'(x);
      DrawY = 10'(y);
      blank = b;
      @(posedge Clk);
      @(posedge Clk);
      #1;
      on  = cloud_on;
      rim = cloud_rim;
   endtask

   // Falling vs edge held low for low_cycles; returns number of tick pulses seen
   task automatic run_tick(input int low_cycles, output int ticks);
      ticks = 0;
      @(negedge Clk);
      vs = 1'b1;
      repeat (2) @(negedge Clk);
      vs = 1'b0;
      for (int i = 0; i < low_cycles; i++) begin
         @(posedge Clk);
         #1;
         if (frame_tick === 1'b1) ticks++;
      end
      @(negedge Clk);
      vs = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge Clk);
         #1;
         if (frame_tick === 1'b1) ticks++;
      end
   endtask

   task automatic test_reset();
      int ticks;
      Reset_n = 1'b0;
      vs = 1'b0;
      blank = 1'b0;
      DrawX = '0;
      DrawY = '0;
      CloudX = '0;
      CloudY = '0;
      CloudS = '0;
      repeat (3) @(posedge Clk);
      #1;
      n_checks++;
      if ({frame_tick, cloud_on, cloud_rim, pix_count, frame_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got tick=%0d on=%0d rim=%0d pix=%0d frames=%0d expected all 0",
                  frame_tick, cloud_on, cloud_rim, pix_count, frame_cnt);
      end
      @(negedge Clk);
      Reset_n = 1'b1;
      ticks = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge Clk);
         #1;
         if (frame_tick === 1'b1) ticks++;
      end
      n_checks++;
      if (ticks !== 0) begin
         n_fail++;
         $display("FAIL reset_no_tick: got %0d ticks expected 0", ticks);
      end
      n_checks++;
      if ({cloud_on, cloud_rim, pix_count, frame_cnt} !== '0) begin
         n_fail++;
         $display("FAIL reset_release_outputs: got on=%0d rim=%0d pix=%0d frames=%0d expected all 0",
                  cloud_on, cloud_rim, pix_count, frame_cnt);
      end
   endtask

   task automatic test_tick_latch();
      int ticks;
      CloudX = 10'd100;
      CloudY = 10'd200;
      CloudS = 10'd50;
      run_tick(3, ticks);
      exp_frames = (exp_frames + 1) % 256;
      n_checks++;
      if (ticks !== 1) begin
         n_fail++;
         $display("FAIL tick_count: got %0d expected 1", ticks);
      end
      n_checks++;
      if (frame_cnt !== 8'(exp_frames)) begin
         n_fail++;
         $display("FAIL tick_frame_cnt: got %0d expected %0d", frame_cnt, exp_frames);
      end
      CloudX = 10'd300;
   endtask

   task automatic test_circle();
      int   xs[9]  = '{150, 151, 100, 130, 100, 100,  60, 1023, 0};
      int   ys[9]  = '{200, 200, 200, 240, 152, 151, 170,  200, 0};
      logic eon[9] = '{1,   0,   1,   1,   1,   1,   1,    0,   0};
      logic erm[9] = '{1,   0,   0,   1,   0,   1,   1,    0,   0};
      logic on, rim;
      for (int i = 0; i < 9; i++) begin
         probe(xs[i], ys[i], 1'b1, on, rim);
         n_checks++;
         if (on !== eon[i] || rim !== erm[i]) begin
            n_fail++;
            $display("FAIL circle(%0d,%0d): got on=%0d rim=%0d expected on=%0d rim=%0d",
                     xs[i], ys[i], on, rim, eon[i], erm[i]);
         end
      end
   endtask

   task automatic test_blank();
      int xs[3] = '{150, 100, 130};
      int ys[3] = '{200, 200, 240};
      logic on, rim;
      for (int i = 0; i < 3; i++) begin
         probe(xs[i], ys[i], 1'b0, on, rim);
         n_checks++;
         if (on !== 1'b0 || rim !== 1'b0) begin
            n_fail++;
            $display("FAIL blank(%0d,%0d): got on=%0d rim=%0d expected on=0 rim=0",
                     xs[i], ys[i], on, rim);
         end
      end
   endtask

   task automatic test_back_to_back();
      int   xs[8]  = '{150, 151, 100, 130, 130, 100, 0, 60};
      int   ys[8]  = '{200, 200, 200, 240, 240, 152, 0, 170};
      logic bs[8]  = '{1,   1,   1,   0,   1,   1,   1, 1};
      logic eon[8] = '{1,   0,   1,   0,   1,   1,   0, 1};
      logic erm[8] = '{1,   0,   0,   0,   1,   0,   0, 1};
      for (int k = 0; k <= 8; k++) begin
         @(negedge Clk);
         if (k < 8) begin
            DrawX = 10'(xs[k]);
            DrawY = 10'(ys[k]);
            blank = bs[k];
         end
         @(posedge Clk);
         #1;
         if (k >= 1) begin
            n_checks++;
            if (cloud_on !== eon[k-1] || cloud_rim !== erm[k-1]) begin
               n_fail++;
               $display("FAIL stream[%0d]: got on=%0d rim=%0d expected on=%0d rim=%0d",
                        k - 1, cloud_on, cloud_rim, eon[k-1], erm[k-1]);
            end
         end
      end
      @(negedge Clk);
      blank = 1'b0;
   endtask

   task automatic test_vs_glitch();
      int ticks;
      int lows[2] = '{1, 8};
      for (int i = 0; i < 2; i++) begin
         run_tick(lows[i], ticks);
         exp_frames = (exp_frames + 1) % 256;
         n_checks++;
         if (ticks !== 1) begin
            n_fail++;
            $display("FAIL vs_low_%0d_ticks: got %0d expected 1", lows[i], ticks);
         end
      end
   endtask

   task automatic test_frame_wrap();
      int ticks;
      for (int i = 0; i < 256; i++) begin
         run_tick(1, ticks);
         exp_frames = (exp_frames + 1) % 256;
         n_checks++;
         if (frame_cnt !== 8'(exp_frames)) begin
            n_fail++;
            $display("FAIL frame_wrap[%0d]: got %0d expected %0d", i, frame_cnt, exp_frames);
         end
      end
   endtask

   task automatic scan_window();
      for (int y = 225; y <= 255; y++) begin
         for (int x = 305; x <= 335; x++) begin
            @(negedge Clk);
            DrawX = 10'(x);
            DrawY = 10'(y);
            blank = 1'b1;
         end
      end
      @(negedge Clk);
      blank = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   task automatic test_coverage();
      int ticks;
      blank = 1'b0;
      CloudX = 10'd320;
      CloudY = 10'd240;
      CloudS = 10'd10;
      run_tick(2, ticks);
      exp_frames = (exp_frames + 1) % 256;
      scan_window();
      run_tick(2, ticks);
      exp_frames = (exp_frames + 1) % 256;
      n_checks++;
      if (pix_count !== 19'd317) begin
         n_fail++;
         $display("FAIL coverage_r10: got %0d expected 317", pix_count);
      end
      run_tick(2, ticks);
      exp_frames = (exp_frames + 1) % 256;
      n_checks++;
      if (pix_count !== 19'd0) begin
         n_fail++;
         $display("FAIL coverage_cleared: got %0d expected 0", pix_count);
      end
   endtask

   task automatic test_degenerate();
      int ticks;
      int   xs0[3]  = '{320, 321, 320};
      int   ys0[3]  = '{240, 240, 239};
      logic eon0[3] = '{1, 0, 0};
      int   xs2[6]  = '{320, 321, 322, 321, 323, 322};
      int   ys2[6]  = '{240, 240, 240, 241, 240, 241};
      logic eon2[6] = '{1, 1, 1, 1, 0, 0};
      logic erm2[6] = '{0, 1, 1, 1, 0, 0};
      logic on, rim;
      CloudS = 10'd0;
      run_tick(2, ticks);
      exp_frames = (exp_frames + 1) % 256;
      scan_window();
      run_tick(2, ticks);
      exp_frames = (exp_frames + 1) % 256;
      n_checks++;
      if (pix_count !== 19'd1) begin
         n_fail++;
         $display("FAIL coverage_r0: got %0d expected 1", pix_count);
      end
      for (int i = 0; i < 3; i++) begin
         probe(xs0[i], ys0[i], 1'b1, on, rim);
         n_checks++;
         if (on !== eon0[i] || rim !== 1'b0) begin
            n_fail++;
            $display("FAIL r0(%0d,%0d): got on=%0d rim=%0d expected on=%0d rim=0",
                     xs0[i], ys0[i], on, rim, eon0[i]);
         end
      end
      @(negedge Clk);
      blank = 1'b0;
      CloudS = 10'd2;
      run_tick(2, ticks);
      exp_frames = (exp_frames + 1) % 256;
      for (int i = 0; i < 6; i++) begin
         probe(xs2[i], ys2[i], 1'b1, on, rim);
         n_checks++;
         if (on !== eon2[i] || rim !== erm2[i]) begin
            n_fail++;
            $display("FAIL r2(%0d,%0d): got on=%0d rim=%0d expected on=%0d rim=%0d",
                     xs2[i], ys2[i], on, rim, eon2[i], erm2[i]);
         end
      end
   endtask

   task automatic test_reset_mid_scan();
      int ticks;
      logic on, rim;
      probe(320, 240, 1'b1, on, rim);
      n_checks++;
      if (on !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_reset_on: got %0d expected 1", on);
      end
      n_checks++;
      if (frame_cnt !== 8'(exp_frames)) begin
         n_fail++;
         $display("FAIL pre_reset_frames: got %0d expected %0d", frame_cnt, exp_frames);
      end
      @(posedge Clk);
      #3;
      Reset_n = 1'b0;
      #1;
      n_checks++;
      if ({frame_tick, cloud_on, cloud_rim, pix_count, frame_cnt} !== '0) begin
         n_fail++;
         $display("FAIL async_reset: got tick=%0d on=%0d rim=%0d pix=%0d frames=%0d expected all 0",
                  frame_tick, cloud_on, cloud_rim, pix_count, frame_cnt);
      end
      blank = 1'b0;
      DrawX = '0;
      DrawY = '0;
      exp_frames = 0;
      @(negedge Clk);
      Reset_n = 1'b1;
      probe(0, 0, 1'b1, on, rim);
      n_checks++;
      if (on !== 1'b1 || rim !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_origin: got on=%0d rim=%0d expected on=1 rim=0", on, rim);
      end
      probe(1, 0, 1'b1, on, rim);
      n_checks++;
      if (on !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_neighbour: got on=%0d expected 0", on);
      end
      @(negedge Clk);
      blank = 1'b0;
      run_tick(2, ticks);
      exp_frames = (exp_frames + 1) % 256;
      n_checks++;
      if (frame_cnt !== 8'(exp_frames)) begin
         n_fail++;
         $display("FAIL post_reset_frames: got %0d expected %0d", frame_cnt, exp_frames);
      end
      n_checks++;
      if (pix_count !== 19'd2) begin
         n_fail++;
         $display("FAIL partial_frame_count: got %0d expected 2", pix_count);
      end
   endtask

   initial begin
      test_reset();
      test_tick_latch();
      test_circle();
      test_blank();
      test_back_to_back();
      test_vs_glitch();
      test_frame_wrap();
      test_coverage();
      test_degenerate();
      test_reset_mid_scan();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
